alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle accumulator ALU.
- Adds a start/done handshake, registered flags and an iterative unit for shifts and the new kMUL (shift-add multiply).
- Sits between the decode/accumulator stage and the writeback mux.
- Single-cycle ops complete in 1 cycle; shifts and multiply take multiple cycles while BUSY is high.

Parameters:
- W, 8, datapath width of INA, INB and OUT (W >= 4)
- IMM_W, 5, width of Imme; Imme is zero-extended to W

Ports:
- CLK  input  1  clock; all state updates on the rising edge
- RESET  input  1  asynchronous, active-high reset
- START  input  1  request; accepted only when BUSY=0
- OP  input  4  opcode of type op_mne
- FLAG  input  1  shift direction: 1 = right, 0 = left
- INA  input  W  accumulator operand
- INB  input  W  register operand
- Imme  input  IMM_W  immediate
- OUT  output  W  result register
- CARRY_OUT  output  1  registered carry/borrow flag
- ISZERO  output  1  registered branch-condition flag
- BUSY  output  1  high while a multi-cycle op is in flight
- DONE  output  1  one-cycle pulse when OUT and the flags are updated

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - OUT=0, CARRY_OUT=0, ISZERO=0, BUSY=0, DONE=0; FSM returns to IDLE.
  - The in-flight op is discarded; no DONE is produced for it.
- Accept rule:
  - An op is accepted on a rising edge with START=1 and BUSY=0.
  - On accept, INA, INB, Imme, OP and FLAG are latched.
  - START while BUSY=1 is ignored, with no queuing.
- FSM states: IDLE, ITER, DONE.
  - IDLE -> DONE on accept of a single-cycle op.
  - IDLE -> ITER on accept of kSL, kSLR or kMUL.
  - ITER -> DONE when the iteration count reaches 0.
  - DONE -> IDLE unconditionally. DONE=1 for that one cycle.
  - In the DONE state, a new START is not accepted.
- Single-cycle ops (latency 1: DONE is high in the cycle after the accept edge):
  - kMOVE: OUT = zext(Imme).
  - kADDI: {C,OUT} = INA + zext(Imme), computed at W+1 bits.
  - kADDR: {C,OUT} = INA + INB.
  - kSUBR: {C,OUT} = INA - INB at W+1 bits, so C=1 exactly when INA < INB (borrow).
  - kSNE / kSEQ / kSLT: OUT = 1 or 0, unsigned compare.
  - kLOAD: OUT = INB. kSTORE: OUT = INA. kOR: OUT = INA | INB.
  - kBEO: ISZERO = (INA == 1). kBEZ: ISZERO = (INA == 0). OUT is held for both.
- Shifts:
  - Amount n = zext(Imme) for kSL, n = INB for kSLR.
  - One bit position per ITER cycle; iterations = min(n, W+1).
  - n=0 still takes one ITER cycle with the value unchanged.
  - Latency = 1 + max(1, min(n, W+1)).
  - Left shift: C = INA[W-n] for 1 <= n <= W, else 0; result 0 for n >= W.
  - Right shift: C = 0; result 0 for n >= W.
- kMUL:
  - Unsigned W x W shift-add over exactly W ITER cycles; latency W+1.
  - OUT = low W bits of the product; C = OR of the high W bits (overflow).
- Flag update rules:
  - CARRY_OUT updates only on kADDI, kADDR, kSUBR, kSL, kSLR, kMUL; all other ops hold it.
  - ISZERO updates on kBEO/kBEZ and is cleared by every other op.
  - OUT, CARRY_OUT and ISZERO change only on the edge that enters DONE, and hold otherwise.
- Unused opcode (15): completes in 1 cycle with DONE; OUT and CARRY_OUT hold; ISZERO clears.

Decomposition:
- Package definitions:
  - op_mne enum extended with kMUL = 4'd14.
  - typedef alu_state_t {IDLE, ITER, DONE}.
  - localparams for the default W and IMM_W.
- Sub-module alu_iter_unit:
  - Holds the shift/multiply registers, the iteration counter and the carry capture.
  - Interface: load, step, finished, result, carry.
  - alu_seq owns the FSM, the single-cycle datapath and the output registers.

Test Plan:
- W=8; kADDR with INA=8'hF0, INB=8'h20 -> DONE one cycle after accept, OUT=8'h10, CARRY_OUT=1, BUSY never high.
- kSUBR with INA=3, INB=5 -> OUT=8'hFE, CARRY_OUT=1; then kOR with INA=8'h0F, INB=8'hF0 -> OUT=8'hFF, CARRY_OUT still 1.
- kSL FLAG=0, INA=8'b1000_0001, Imme=1 -> latency 2, OUT=8'h02, CARRY_OUT=1; repeat with Imme=9 -> latency 10, OUT=0, CARRY_OUT=0.
- kMUL with INA=8'd20, INB=8'd13 -> BUSY high 8 cycles, DONE at latency 9, OUT=8'h04, CARRY_OUT=1 (product 260); START pulsed during BUSY is ignored, giving exactly one DONE.
- kBEZ with INA=0 -> ISZERO=1 and OUT unchanged; the following kMOVE with Imme=5 -> OUT=5, ISZERO=0.
- Assert RESET mid-kMUL (cycle 4) -> all outputs 0 immediately (asynchronous), no DONE; after release, kADDI with INA=1, Imme=2 gives OUT=3.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared types and defaults for the registered sequential ALU.
package alu_seq_pkg;

    localparam int ALU_W_DEF     = 8;
    localparam int ALU_IMM_W_DEF = 5;

    // Opcode set of the accumulator ALU; 4'd15 is left unused.
    typedef enum logic [3:0] {
        kMOVE  = 4'd0,
        kADDI  = 4'd1,
        kADDR  = 4'd2,
        kSUBR  = 4'd3,
        kSNE   = 4'd4,
        kSEQ   = 4'd5,
        kSLT   = 4'd6,
        kLOAD  = 4'd7,
        kSTORE = 4'd8,
        kOR    = 4'd9,
        kBEO   = 4'd10,
        kBEZ   = 4'd11,
        kSL    = 4'd12,
        kSLR   = 4'd13,
        kMUL   = 4'd14
    } op_mne;

    // State names carry a prefix so they never collide with the DONE port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    // What the iterative unit does on each step.
    typedef enum logic [1:0] {
        IT_SHL = 2'd0,
        IT_SHR = 2'd1,
        IT_MUL = 2'd2
    } iter_mode_t;

    // Ops that go through the iterative unit instead of completing at once.
    function automatic logic is_iter_op(input op_mne op);
        return (op == kSL) || (op == kSLR) || (op == kMUL);
    endfunction

endpackage

// File: rtl/alu_seq_iter.sv
// Iterative unit: one-bit-per-step shifts and shift-add multiply.
// result_o/carry_o show the value the current step produces, so the owner
// can capture them on the same edge that finished_o marks as the last step.
module alu_seq_iter
    import alu_seq_pkg::*;
#(
    parameter int W     = ALU_W_DEF,
    parameter int IMM_W = ALU_IMM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             step_i,
    input  op_mne            op_i,
    input  logic             flag_i,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [IMM_W-1:0] imm_i,
    output logic             finished_o,
    output logic [W-1:0]     result_o,
    output logic             carry_o
);

    localparam int N_W   = (W > IMM_W) ? W : IMM_W;
    localparam int CNT_W = $clog2(W + 2);
    localparam logic [N_W:0]     MAX_N   = (N_W + 1)'(W + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(W + 1);
    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(W);

    logic [2*W-1:0]   data_q, data_d;
    logic [W-1:0]     mcand_q;
    logic [CNT_W-1:0] cnt_q, iters;
    logic             noshift_q;
    iter_mode_t       mode_q, mode_ld;
    logic [N_W-1:0]   amount;
    logic [W:0]       sum;
    logic             carry_d;

    // Shift amount and iteration count decided at load time.
    always_comb begin
        amount  = (op_i == kSL) ? N_W'(imm_i) : N_W'(b_i);
        mode_ld = (op_i == kMUL) ? IT_MUL : (flag_i ? IT_SHR : IT_SHL);
        if (amount == '0) begin
            iters = CNT_W'(1);
        end else if ({1'b0, amount} > MAX_N) begin
            iters = MAX_CNT;
        end else begin
            iters = CNT_W'(amount);
        end
    end

    // Value and carry produced by one step from the current registers.
    always_comb begin
        data_d  = data_q;
        carry_d = 1'b0;
        sum     = '0;
        case (mode_q)
            IT_SHL: begin
                if (!noshift_q) begin
                    data_d[W-1:0] = {data_q[W-2:0], 1'b0};
                    carry_d       = data_q[W-1];
                end
            end
            IT_SHR: begin
                if (!noshift_q) begin
                    data_d[W-1:0] = {1'b0, data_q[W-1:1]};
                end
            end
            IT_MUL: begin
                sum     = {1'b0, data_q[2*W-1:W]} + (data_q[0] ? {1'b0, mcand_q} : '0);
                data_d  = {sum, data_q[W-1:1]};
                carry_d = |data_d[2*W-1:W];
            end
            default: begin
                data_d = data_q;
            end
        endcase
    end

    assign result_o   = data_d[W-1:0];
    assign carry_o    = carry_d;
    assign finished_o = (cnt_q == CNT_W'(1));

    // Operand capture on load, one step per cycle afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q    <= '0;
            mcand_q   <= '0;
            cnt_q     <= '0;
            noshift_q <= 1'b0;
            mode_q    <= IT_SHL;
        end else if (load_i) begin
            mode_q    <= mode_ld;
            mcand_q   <= a_i;
            data_q    <= (op_i == kMUL) ? {{W{1'b0}}, b_i} : {{W{1'b0}}, a_i};
            cnt_q     <= (op_i == kMUL) ? MUL_CNT : iters;
            noshift_q <= (op_i != kMUL) && (amount == '0);
        end else if (step_i && (cnt_q != '0)) begin
            data_q <= data_d;
            cnt_q  <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered accumulator ALU with start/done handshake.
// Handshake: an op is taken on a rising edge where START=1 and the FSM is
// idle (BUSY=0 and not in the DONE cycle); START at any other time is dropped,
// nothing is queued. DONE pulses for exactly one cycle when OUT and the flags
// have just been updated. BUSY is high only while the iterative unit runs.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int W     = ALU_W_DEF,
    parameter int IMM_W = ALU_IMM_W_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  op_mne            OP,
    input  logic             FLAG,
    input  logic [W-1:0]     INA,
    input  logic [W-1:0]     INB,
    input  logic [IMM_W-1:0] Imme,
    output logic [W-1:0]     OUT,
    output logic             CARRY_OUT,
    output logic             ISZERO,
    output logic             BUSY,
    output logic             DONE
);

    alu_state_t   state_q;
    logic [W-1:0] out_q, out_d;
    logic         carry_q, carry_d;
    logic         iszero_q, iszero_d;
    logic         busy_q, done_q;

    logic [W-1:0] imm_ext;
    logic [W:0]   add_imm, add_reg, sub_reg;
    logic         accept, iter_load, iter_step, iter_finished, iter_carry;
    logic [W-1:0] iter_result;

    assign accept    = START && (state_q == ST_IDLE);
    assign iter_load = accept && is_iter_op(OP);
    assign iter_step = (state_q == ST_ITER);

    assign imm_ext = W'(Imme);
    assign add_imm = {1'b0, INA} + {1'b0, imm_ext};
    assign add_reg = {1'b0, INA} + {1'b0, INB};
    assign sub_reg = {1'b0, INA} - {1'b0, INB};

    // Single-cycle results; unlisted ops hold OUT/CARRY_OUT and clear ISZERO.
    always_comb begin
        out_d    = out_q;
        carry_d  = carry_q;
        iszero_d = 1'b0;
        case (OP)
            kMOVE:  out_d = imm_ext;
            kADDI:  {carry_d, out_d} = add_imm;
            kADDR:  {carry_d, out_d} = add_reg;
            kSUBR:  {carry_d, out_d} = sub_reg;
            kSNE:   out_d = W'(INA != INB);
            kSEQ:   out_d = W'(INA == INB);
            kSLT:   out_d = W'(INA < INB);
            kLOAD:  out_d = INB;
            kSTORE: out_d = INA;
            kOR:    out_d = INA | INB;
            kBEO:   iszero_d = (INA == W'(1));
            kBEZ:   iszero_d = (INA == '0);
            default: out_d = out_q;
        endcase
    end

    alu_seq_iter #(
        .W     (W),
        .IMM_W (IMM_W)
    ) u_iter (
        .clk        (CLK),
        .rst        (RESET),
        .load_i     (iter_load),
        .step_i     (iter_step),
        .op_i       (OP),
        .flag_i     (FLAG),
        .a_i        (INA),
        .b_i        (INB),
        .imm_i      (Imme),
        .finished_o (iter_finished),
        .result_o   (iter_result),
        .carry_o    (iter_carry)
    );

    // Control FSM with registered outputs; results land on the edge entering DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            out_q    <= '0;
            carry_q  <= 1'b0;
            iszero_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        if (is_iter_op(OP)) begin
                            state_q <= ST_ITER;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q  <= ST_DONE;
                            done_q   <= 1'b1;
                            out_q    <= out_d;
                            carry_q  <= carry_d;
                            iszero_q <= iszero_d;
                        end
                    end
                end
                ST_ITER: begin
                    if (iter_finished) begin
                        state_q  <= ST_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        out_q    <= iter_result;
                        carry_q  <= iter_carry;
                        iszero_q <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign OUT       = out_q;
    assign CARRY_OUT = carry_q;
    assign ISZERO    = iszero_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule
